// File: rtl/fir_rf_pkg.sv
// Shared constants and address helpers for the multi-channel FIR tap register file.
package fir_rf_pkg;

   localparam logic WMODE_ABS  = 1'b0;
   localparam logic WMODE_PUSH = 1'b1;
   localparam logic RMODE_ABS  = 1'b0;
   localparam logic RMODE_TAP  = 1'b1;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 64;
   localparam int DEF_NCH   = 4;

   // Newest sample sits one slot behind head; depth is a power of two so masking wraps.
   function automatic int unsigned tap_to_phys(input int unsigned head,
                                               input int unsigned tap,
                                               input int unsigned depth);
      return (head - 32'd1 - tap) & (depth - 32'd1);
   endfunction

endpackage

// File: rtl/fir_rf_ptr.sv
// One channel's circular-line bookkeeping: head pointer, saturating fill count,
// full flag and tap-to-physical address translation.
module fir_rf_ptr
   import fir_rf_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk2,
   input  logic              rst,
   input  logic              push_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] tap_i,
   output logic [ADDR_W-1:0] head_o,
   output logic [ADDR_W-1:0] phys_o,
   output logic              tap_hit_o,
   output logic              full_o
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] head_q, head_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;

   always_ff @(posedge clk2) begin
      if (rst) begin
         head_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   // A clear in the same cycle as a push discards the push.
   always_comb begin
      head_d  = head_q;
      count_d = count_q;
      if (clr_i) begin
         head_d  = '0;
         count_d = '0;
      end else if (push_i) begin
         head_d = head_q + ADDR_W'(1);
         if (count_q != FULL_CNT) begin
            count_d = count_q + (ADDR_W+1)'(1);
         end
      end
      full_d = (count_d == FULL_CNT);
   end

   assign head_o    = head_q;
   assign phys_o    = ADDR_W'(tap_to_phys(32'(head_q), 32'(tap_i), DEPTH));
   assign tap_hit_o = ({1'b0, tap_i} < count_q);
   assign full_o    = full_q;

endmodule

// File: rtl/fir_tap_regfile.sv
// Multi-channel FIR sample/coefficient store: addressed register file or
// per-channel circular delay line with zero-filled tap reads.
module fir_tap_regfile
   import fir_rf_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NCH    = DEF_NCH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    clk2,
   input  logic                    rst,
   input  logic                    wen,
   input  logic                    wmode,
   input  logic [CH_W-1:0]         wch,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic signed [WIDTH-1:0] din,
   input  logic                    ren,
   input  logic                    rmode,
   input  logic [CH_W-1:0]         rch,
   input  logic [ADDR_W-1:0]       raddr,
   output logic signed [WIDTH-1:0] dout,
   output logic                    dout_vld,
   input  logic                    clr,
   input  logic [CH_W-1:0]         clr_ch,
   output logic [NCH-1:0]          full
);

   logic signed [WIDTH-1:0] mem_q [NCH][DEPTH];
   logic [ADDR_W-1:0]       head_w [NCH];
   logic [ADDR_W-1:0]       phys_w [NCH];
   logic [NCH-1:0]          tap_hit_w;

   logic signed [WIDTH-1:0] dout_q, dout_d;
   logic                    vld_q;

   logic                    push_clr_collide;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_waddr;
   logic [ADDR_W-1:0]       rd_addr;
   logic                    abs_bypass;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic push_c;
      logic clr_c;
      assign push_c = wen && (wmode == WMODE_PUSH) && (wch == CH_W'(c));
      assign clr_c  = clr && (clr_ch == CH_W'(c));

      fir_rf_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ptr (
         .clk2      (clk2),
         .rst       (rst),
         .push_i    (push_c),
         .clr_i     (clr_c),
         .tap_i     (raddr),
         .head_o    (head_w[c]),
         .phys_o    (phys_w[c]),
         .tap_hit_o (tap_hit_w[c]),
         .full_o    (full[c])
      );
   end

   assign push_clr_collide = clr && (clr_ch == wch);
   assign mem_we    = wen && !rst && ((wmode == WMODE_ABS) || !push_clr_collide);
   assign mem_waddr = (wmode == WMODE_PUSH) ? head_w[wch] : waddr;

   always_ff @(posedge clk2) begin
      if (mem_we) begin
         mem_q[wch][mem_waddr] <= din;
      end
   end

   // Tap reads always see pre-edge memory; only absolute reads bypass a same-cycle write.
   assign rd_addr    = (rmode == RMODE_TAP) ? phys_w[rch] : raddr;
   assign abs_bypass = (rmode == RMODE_ABS) && wen && (wmode == WMODE_ABS) &&
                       (wch == rch) && (waddr == raddr);

   always_comb begin
      dout_d = mem_q[rch][rd_addr];
      if (abs_bypass) begin
         dout_d = din;
      end else if ((rmode == RMODE_TAP) && !tap_hit_w[rch]) begin
         dout_d = '0;
      end
   end

   always_ff @(posedge clk2) begin
      if (rst) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= ren;
         if (ren) begin
            dout_q <= dout_d;
         end
      end
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;

endmodule

// File: tb/tb_fir_tap_regfile.sv
// Self-checking bench for fir_tap_regfile against a per-channel array/pointer model.
module tb_fir_tap_regfile;

   localparam int W  = 16;
   localparam int D  = 64;
   localparam int N  = 4;
   localparam int AW = 6;
   localparam int CW = 2;

   logic                clk2;
   logic                rst;
   logic                wen, wmode, ren, rmode, clr;
   logic [CW-1:0]       wch, rch, clr_ch;
   logic [AW-1:0]       waddr, raddr;
   logic signed [W-1:0] din;
   logic signed [W-1:0] dout;
   logic                dout_vld;
   logic [N-1:0]        full;

   fir_tap_regfile #(.WIDTH(W), .DEPTH(D), .NCH(N)) dut (
      .clk2     (clk2),
      .rst      (rst),
      .wen      (wen),
      .wmode    (wmode),
      .wch      (wch),
      .waddr    (waddr),
      .din      (din),
      .ren      (ren),
      .rmode    (rmode),
      .rch      (rch),
      .raddr    (raddr),
      .dout     (dout),
      .dout_vld (dout_vld),
      .clr      (clr),
      .clr_ch   (clr_ch),
      .full     (full)
   );

   initial clk2 = 1'b0;
   always #5 clk2 = ~clk2;

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [W-1:0] m_mem [N][D];
   int                  m_head [N];
   int                  m_cnt  [N];
   logic signed [W-1:0] exp_dout;
   logic                exp_vld;
   logic [N-1:0]        exp_full;

   // Drives one cycle of stimulus; the model resolves the read from pre-edge state, then applies updates.
   task automatic step(input logic wen_, input logic wmode_, input int wch_, input int waddr_,
                       input logic signed [W-1:0] din_, input logic ren_, input logic rmode_,
                       input int rch_, input int raddr_, input logic clr_, input int clrch_,
                       input logic rst_);
      int phys;
      wen = wen_; wmode = wmode_; wch = CW'(wch_); waddr = AW'(waddr_); din = din_;
      ren = ren_; rmode = rmode_; rch = CW'(rch_); raddr = AW'(raddr_);
      clr = clr_; clr_ch = CW'(clrch_); rst = rst_;
      if (rst_) begin
         exp_dout = '0;
         exp_vld  = 1'b0;
         for (int c = 0; c < N; c++) begin
            m_head[c] = 0;
            m_cnt[c]  = 0;
         end
      end else begin
         exp_vld = ren_;
         if (ren_) begin
            if (!rmode_) begin
               if (wen_ && !wmode_ && wch_ == rch_ && waddr_ == raddr_) exp_dout = din_;
               else exp_dout = m_mem[rch_][raddr_];
            end else if (raddr_ < m_cnt[rch_]) begin
               phys = ((m_head[rch_] - 1 - raddr_) % D + D) % D;
               exp_dout = m_mem[rch_][phys];
            end else begin
               exp_dout = '0;
            end
         end
         if (wen_) begin
            if (!wmode_) begin
               m_mem[wch_][waddr_] = din_;
            end else if (!(clr_ && clrch_ == wch_)) begin
               m_mem[wch_][m_head[wch_]] = din_;
               m_head[wch_] = (m_head[wch_] + 1) % D;
               if (m_cnt[wch_] < D) m_cnt[wch_] = m_cnt[wch_] + 1;
            end
         end
         if (clr_) begin
            m_head[clrch_] = 0;
            m_cnt[clrch_]  = 0;
         end
      end
      for (int c = 0; c < N; c++) exp_full[c] = (m_cnt[c] == D);
      @(posedge clk2);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic abs_wr(input int ch, input int a, input logic signed [W-1:0] v);
      step(1, 0, ch, a, v, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic abs_rd(input int ch, input int a);
      step(0, 0, 0, 0, '0, 1, 0, ch, a, 0, 0, 0);
   endtask

   task automatic push(input int ch, input logic signed [W-1:0] v);
      step(1, 1, ch, 0, v, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tap_rd(input int ch, input int t);
      step(0, 0, 0, 0, '0, 1, 1, ch, t, 0, 0, 0);
   endtask

   task automatic test_reset();
      step(0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 1);
      n_cmp++;
      if (dout !== 16'sd0) begin n_bad++; $display("FAIL reset_dout got=%0h want=0", dout); end
      n_cmp++;
      if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got=%b want=0", dout_vld); end
      n_cmp++;
      if (full !== '0) begin n_bad++; $display("FAIL reset_full got=%b want=0", full); end
      for (int c = 0; c < N; c++)
         for (int a = 0; a < D; a++) abs_wr(c, a, W'($urandom));
      n_cmp++;
      if (full !== '0) begin n_bad++; $display("FAIL preload_full got=%b want=0", full); end
   endtask

   task automatic test_abs_rw();
      logic signed [W-1:0] wv [D];
      for (int a = 0; a < D; a++) begin
         wv[a] = W'($urandom);
         abs_wr(2, a, wv[a]);
      end
      for (int a = 0; a < D; a++) begin
         abs_rd(2, a);
         n_cmp++;
         if (dout !== wv[a] || dout !== exp_dout) begin
            n_bad++; $display("FAIL abs_rd[%0d] got=%0h want=%0h", a, dout, wv[a]);
         end
         n_cmp++;
         if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL abs_vld[%0d] got=%b want=1", a, dout_vld); end
      end
      idle();
      n_cmp++;
      if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL abs_vld_drop got=%b want=0", dout_vld); end
      n_cmp++;
      if (dout !== wv[D-1]) begin n_bad++; $display("FAIL abs_hold got=%0h want=%0h", dout, wv[D-1]); end
   endtask

   task automatic test_fill();
      logic signed [W-1:0] want [4];
      want[0] = 16'sd7; want[1] = 16'sd6; want[2] = 16'sd5; want[3] = 16'sd0;
      for (int k = 5; k <= 7; k++) begin
         push(0, W'(k));
         n_cmp++;
         if (full[0] !== 1'b0) begin n_bad++; $display("FAIL fill_full0 push=%0d got=%b want=0", k, full[0]); end
      end
      for (int t = 0; t < 4; t++) begin
         tap_rd(0, t);
         n_cmp++;
         if (dout !== want[t] || dout !== exp_dout) begin
            n_bad++; $display("FAIL fill_tap%0d got=%0d want=%0d", t, dout, want[t]);
         end
      end
   endtask

   task automatic test_wrap();
      for (int k = 1; k <= 70; k++) begin
         push(1, W'(k));
         n_cmp++;
         if (full !== exp_full || full[1] !== (k >= D)) begin
            n_bad++; $display("FAIL wrap_full push=%0d got=%b want=%b", k, full, exp_full);
         end
      end
      tap_rd(1, 0);
      n_cmp++;
      if (dout !== 16'sd70 || dout !== exp_dout) begin n_bad++; $display("FAIL wrap_tap0 got=%0d want=70", dout); end
      tap_rd(1, 63);
      n_cmp++;
      if (dout !== 16'sd7 || dout !== exp_dout) begin n_bad++; $display("FAIL wrap_tap63 got=%0d want=7", dout); end
   endtask

   task automatic test_same_cycle();
      step(1, 0, 3, 10, 16'sh1234, 1, 0, 3, 10, 0, 0, 0);
      n_cmp++;
      if (dout !== 16'sh1234) begin n_bad++; $display("FAIL bypass got=%0h want=1234", dout); end
      step(1, 1, 1, 0, 16'sd99, 1, 1, 1, 63, 0, 0, 0);
      n_cmp++;
      if (dout !== 16'sd7 || dout !== exp_dout) begin n_bad++; $display("FAIL push_tap63 got=%0d want=7", dout); end
      tap_rd(1, 0);
      n_cmp++;
      if (dout !== 16'sd99) begin n_bad++; $display("FAIL after_push_tap0 got=%0d want=99", dout); end
      tap_rd(1, 63);
      n_cmp++;
      if (dout !== 16'sd8 || dout !== exp_dout) begin n_bad++; $display("FAIL after_push_tap63 got=%0d want=8", dout); end
   endtask

   task automatic test_clear();
      step(0, 0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 0);
      n_cmp++;
      if (full !== exp_full || full[1] !== 1'b0) begin n_bad++; $display("FAIL clr_full got=%b want=%b", full, exp_full); end
      tap_rd(1, 0);
      n_cmp++;
      if (dout !== 16'sd0) begin n_bad++; $display("FAIL clr_tap0 got=%0d want=0", dout); end
      step(1, 1, 1, 0, 16'sd55, 0, 0, 0, 0, 1, 1, 0);
      tap_rd(1, 0);
      n_cmp++;
      if (dout !== 16'sd0) begin n_bad++; $display("FAIL clr_push_tap0 got=%0d want=0", dout); end
      step(1, 0, 1, 5, 16'sd777, 0, 0, 0, 0, 1, 1, 0);
      abs_rd(1, 5);
      n_cmp++;
      if (dout !== 16'sd777) begin n_bad++; $display("FAIL clr_abs_wr got=%0d want=777", dout); end
      for (int t = 0; t < 3; t++) begin
         tap_rd(0, t);
         n_cmp++;
         if (dout !== 16'(7 - t)) begin n_bad++; $display("FAIL clr_ch0_tap%0d got=%0d want=%0d", t, dout, 7 - t); end
      end
      abs_rd(3, 10);
      n_cmp++;
      if (dout !== 16'sh1234) begin n_bad++; $display("FAIL clr_ch3 got=%0h want=1234", dout); end
      abs_rd(2, 17);
      n_cmp++;
      if (dout !== exp_dout) begin n_bad++; $display("FAIL clr_ch2 got=%0h want=%0h", dout, exp_dout); end
      n_cmp++;
      if (full !== 4'b0000) begin n_bad++; $display("FAIL clr_full_all got=%b want=0000", full); end
   endtask

   task automatic test_random();
      logic we, wm, re, rm, cl;
      int wc, wa, rc, ra, cc;
      for (int i = 0; i < 600; i++) begin
         we = 1'($urandom); wm = ($urandom_range(0, 3) != 0);
         re = ($urandom_range(0, 3) != 0); rm = 1'($urandom);
         cl = ($urandom_range(0, 15) == 0);
         wc = $urandom_range(0, N - 1); wa = $urandom_range(0, D - 1);
         rc = $urandom_range(0, 1) ? wc : $urandom_range(0, N - 1);
         ra = $urandom_range(0, 3) == 0 ? wa : $urandom_range(0, D - 1);
         cc = $urandom_range(0, 1) ? wc : $urandom_range(0, N - 1);
         step(we, wm, wc, wa, W'($urandom), re, rm, rc, ra, cl, cc, 0);
         n_cmp++;
         if (dout_vld !== exp_vld) begin n_bad++; $display("FAIL rnd_vld[%0d] got=%b want=%b", i, dout_vld, exp_vld); end
         n_cmp++;
         if (dout !== exp_dout) begin n_bad++; $display("FAIL rnd_dout[%0d] got=%0h want=%0h", i, dout, exp_dout); end
         n_cmp++;
         if (full !== exp_full) begin n_bad++; $display("FAIL rnd_full[%0d] got=%b want=%b", i, full, exp_full); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) step(1, 1, 2, 0, W'($urandom), 1, 1, 2, 0, 0, 0, 0);
      step(1, 1, 2, 0, 16'sd321, 1, 1, 2, 0, 0, 0, 1);
      n_cmp++;
      if (dout !== 16'sd0) begin n_bad++; $display("FAIL rstmid_dout got=%0h want=0", dout); end
      n_cmp++;
      if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_vld got=%b want=0", dout_vld); end
      n_cmp++;
      if (full !== '0) begin n_bad++; $display("FAIL rstmid_full got=%b want=0", full); end
      tap_rd(2, 0);
      n_cmp++;
      if (dout !== 16'sd0 || dout_vld !== 1'b1) begin
         n_bad++; $display("FAIL rstmid_tap0 got=%0d/%b want=0/1", dout, dout_vld);
      end
      push(2, 16'sd42);
      tap_rd(2, 0);
      n_cmp++;
      if (dout !== 16'sd42) begin n_bad++; $display("FAIL rstmid_push got=%0d want=42", dout); end
   endtask

   initial begin
      rst = 1'b1; wen = 0; wmode = 0; wch = '0; waddr = '0; din = '0;
      ren = 0; rmode = 0; rch = '0; raddr = '0; clr = 0; clr_ch = '0;
      exp_dout = '0; exp_vld = 0; exp_full = '0;
      test_reset();
      test_abs_rw();
      test_fill();
      test_wrap();
      test_same_cycle();
      test_clear();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fir_tap_regfile.md
# fir_tap_regfile

Parametrised, multi-channel successor to the single-bank FIR register file. It holds NCH independent banks of DEPTH samples each. Every bank can be used in two ways: as a plain addressed register file for coefficient load, or as a circular delay line that is pushed one sample at a time and read by tap index, with zero-fill while the line is still filling. It sits between the sample front-end and the FIR MAC datapath and has one registered read port and one write port.

## Interface
- WIDTH, 16: sample/coefficient width in bits (signed).
- DEPTH, 64: entries per channel; must be a power of 2, ≥ 2.
- NCH, 4: number of channels (banks); ≥ 1.
- ADDR_W, $clog2(DEPTH): address and tap-index width (derived).
- CH_W, max(1,$clog2(NCH)): channel-select width (derived).
- clk2  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- wen  in  1  write strobe.
- wmode  in  1  write mode: 0 = absolute write at waddr, 1 = push at the channel head (waddr ignored).
- wch  in  CH_W  write channel.
- waddr  in  ADDR_W  absolute write address.
- din  in  WIDTH  signed write data.
- ren  in  1  read strobe.
- rmode  in  1  read mode: 0 = absolute at raddr, 1 = tap-relative (raddr = tap index, tap 0 = newest sample).
- rch  in  CH_W  read channel.
- raddr  in  ADDR_W  read address or tap index.
- dout  out  WIDTH  signed registered read data.
- dout_vld  out  1  high exactly one cycle after an accepted ren.
- clr  in  1  clears the head pointer and fill count of channel clr_ch.
- clr_ch  in  CH_W  channel to clear.
- full  out  NCH  per channel: count == DEPTH.

## Operation
- Per-channel state:
  - head[ADDR_W]: next push slot.
  - count: 0..DEPTH, saturating.
  - Storage array: NCH×DEPTH×WIDTH. The array is not reset.
- Absolute write (wen, wmode=0): mem[wch][waddr] <= din. head and count are unchanged.
- Push (wen, wmode=1):
  - mem[wch][head] <= din.
  - head <= head+1, wrapping modulo DEPTH.
  - count <= min(count+1, DEPTH).
- Absolute read: dout <= mem[rch][raddr].
- Tap read: let phys = (head − 1 − raddr) mod DEPTH.
  - If raddr < count: dout <= mem[rch][phys].
  - Otherwise: dout <= 0 (zero-fill).
- When ren=0: dout holds its last value and dout_vld <= 0.
- Clear (clr): head[clr_ch] <= 0, count[clr_ch] <= 0. Memory contents are retained.
- Simultaneous events:
  - Absolute read and write to the same channel and address in the same cycle: dout returns the new din (write-through bypass).
  - Tap read and push to the same channel in the same cycle: the read uses the pre-edge head, count and memory. On a full channel, tap DEPTH−1 returns the sample being overwritten, not din.
  - clr and push to the same channel in the same cycle: clr wins and the push is discarded (memory not written).
  - clr and tap read to the same channel in the same cycle: the read uses the pre-clear state.
  - Absolute write and clr in the same cycle: both take effect.
- Reset, including mid-operation:
  - All head <= 0, count <= 0.
  - dout <= 0, dout_vld <= 0, full <= 0.
  - Reset has priority over wen, ren and clr in that cycle.

## Timing
- Read latency is 1 cycle: dout/dout_vld change on the edge that samples ren.
- Back-to-back reads are allowed every cycle with full throughput.
- Writes are visible to reads issued on the next cycle; the same-cycle absolute bypass is defined above.
- full and the count it is derived from update on the same edge as the push or clear; both are registered outputs.
- There are no stalls and no handshake beyond the strobes. Any combination of wen, ren and clr is legal in every cycle.

## Structure
- Package fir_rf_pkg holds:
  - the WMODE_ABS/WMODE_PUSH and RMODE_ABS/RMODE_TAP constants;
  - the default WIDTH/DEPTH/NCH localparams;
  - a tap-to-physical address helper function.
- Sub-module fir_rf_ptr holds one channel's head/count tracker: push, clr and full logic plus phys-address generation. It is instantiated NCH times.
- The top level holds the storage array, the bypass mux, the zero-fill mux and the output register.

## Test plan
1. Absolute write then read: write all 64 entries of ch2 with distinct random values, then read them back in address order with ren held high. Every dout must match the written value, with dout_vld high from the cycle after the first read.
2. Tap read while filling: push 5, 6, 7 into ch0.
   - Taps 0, 1, 2 must return 7, 6, 5.
   - Tap 3 must return 0.
   - full[0] must stay 0.
3. Wrap-around: push 70 samples (values 1..70) into ch1.
   - full[1]=1 from the 64th push onward.
   - Tap 0 returns 70; tap 63 returns 7.
4. Same-cycle events:
   - Absolute write of 0x1234 to ch3 addr 10 with an absolute read of the same address: dout must be 0x1234 on the next cycle.
   - On a full ch1, push 99 together with a tap-63 read: dout must be 7.
5. Clear:
   - After scenario 3, pulse clr for ch1; tap 0 must then return 0 and full[1] must be 0.
   - clr together with a push to ch1: count must stay 0.
   - Channels 0, 2 and 3 must be unaffected throughout.
6. Reset mid-stream: assert rst for 1 cycle during a push/read burst.
   - On the next cycle dout=0, dout_vld=0 and full=0.
   - A following tap-0 read must return 0.
